// File: rtl/axis_bitstream_decim.sv
// axis_bitstream_decim: second-order CIC (sinc^2) decimator. It turns a 1-bit
// density stream into WIDTH-bit unsigned PCM, producing one sample per
// 2^DECIM_LOG2 accepted bits. Both AXI-Stream sides support backpressure.
// Optional build macro DECIM_WARMUP_MASK_EN hides the two comb warm-up frames
// after reset.
module axis_bitstream_decim #(
    parameter int WIDTH      = 16,
    parameter int DECIM_LOG2 = 4
) (
    input  logic             aclk,
    input  logic             arst,
    input  logic             s_axis_data_tdata,
    input  logic             s_axis_data_tvalid,
    output logic             s_axis_data_tready,
    output logic [WIDTH-1:0] m_axis_data_tdata,
    output logic             m_axis_data_tvalid,
    input  logic             m_axis_data_tready
);

    // Integrators and combs are narrow on purpose. The true comb output lies in
    // 0..R^2, so modular wrap at N bits recovers it exactly.
    localparam int N  = 2*DECIM_LOG2 + 1;
    localparam int SH = WIDTH - 2*DECIM_LOG2;
    localparam logic [DECIM_LOG2-1:0] PHASE_LAST = '1;
    localparam logic [N-1:0]          R_SQ       = N'(1) << (2*DECIM_LOG2);

    // Scale the comb output to full WIDTH. R^2 (an all-ones input frame) would
    // overflow by one LSB, so it is pinned to full scale.
    function automatic logic [WIDTH-1:0] sat_scale(input logic [N-1:0] c);
        logic [WIDTH+N-1:0] wide;
        wide = {{WIDTH{1'b0}}, c} << SH;
        if (c >= R_SQ)
            return '1;
        return wide[WIDTH-1:0];
    endfunction

    logic [N-1:0]            i1_p0, i2_p0;
    logic [DECIM_LOG2-1:0]   phase_p0;
    logic [N-1:0]            s_d_p1, c1_d_p1;
    logic [WIDTH-1:0]        out_data_p2;
    logic                    vld_p2;

    logic                    frame_end, accept, load, show;
    logic [N-1:0]            bit_ext, s_sum, c1, c2;

    assign frame_end          = (phase_p0 == PHASE_LAST);
    // Stall only the beat that would complete a frame while the previous
    // sample still sits unclaimed in the output register.
    assign s_axis_data_tready = ~(frame_end & vld_p2 & ~m_axis_data_tready);
    assign accept             = s_axis_data_tvalid & s_axis_data_tready;
    assign load               = accept & frame_end;

    assign bit_ext = {{(N-1){1'b0}}, s_axis_data_tdata};
    assign s_sum   = i2_p0 + i1_p0;
    assign c1      = s_sum - s_d_p1;
    assign c2      = c1 - c1_d_p1;

`ifdef DECIM_WARMUP_MASK_EN
    logic [1:0] warm_p1;

    assign show = warm_p1[1];

    // Count the two warm-up frames after reset; saturates once at 2.
    always_ff @(posedge aclk) begin
        if (arst)
            warm_p1 <= 2'd0;
        else if (load && !warm_p1[1])
            warm_p1 <= warm_p1 + 2'd1;
    end
`else
    assign show = 1'b1;
`endif

    // --- stage p0: integrators and frame phase, advance on every accepted bit
    always_ff @(posedge aclk) begin
        if (arst) begin
            i1_p0    <= '0;
            i2_p0    <= '0;
            phase_p0 <= '0;
        end else if (accept) begin
            i1_p0    <= i1_p0 + bit_ext;
            i2_p0    <= s_sum;
            phase_p0 <= phase_p0 + DECIM_LOG2'(1);
        end
    end

    // --- stage p1: comb delay lines, updated once per frame
    always_ff @(posedge aclk) begin
        if (arst) begin
            s_d_p1  <= '0;
            c1_d_p1 <= '0;
        end else if (load) begin
            s_d_p1  <= s_sum;
            c1_d_p1 <= c1;
        end
    end

    // --- stage p2: output register; a new load wins over a same-cycle drain
    always_ff @(posedge aclk) begin
        if (arst) begin
            out_data_p2 <= '0;
            vld_p2      <= 1'b0;
        end else if (load && show) begin
            out_data_p2 <= sat_scale(c2);
            vld_p2      <= 1'b1;
        end else if (vld_p2 && m_axis_data_tready) begin
            vld_p2      <= 1'b0;
        end
    end

    assign m_axis_data_tdata  = out_data_p2;
    assign m_axis_data_tvalid = vld_p2;

endmodule

// File: tb/tb_axis_bitstream_decim.sv
// Directed testbench for axis_bitstream_decim (WIDTH=16, DECIM_LOG2=4).
// Follows DECIM_WARMUP_MASK_EN when the same macro is given to the build.
module tb_axis_bitstream_decim;

`ifdef DECIM_WARMUP_MASK_EN
    localparam int SKIP      = 2;
    localparam int HOLD_CYC  = 70;
    localparam int HOLD_ACC  = 63;
    localparam int PEND_ACC  = 55;
    localparam int FIRST_ACC = 48;
    localparam logic [15:0] FIRST_ONES = 16'hFFFF;
`else
    localparam int SKIP      = 0;
    localparam int HOLD_CYC  = 40;
    localparam int HOLD_ACC  = 31;
    localparam int PEND_ACC  = 23;
    localparam int FIRST_ACC = 16;
    localparam logic [15:0] FIRST_ONES = 16'h7800;
`endif

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic        s_axis_data_tdata = 1'b0;
    logic        s_axis_data_tvalid = 1'b0;
    logic        s_axis_data_tready;
    logic [15:0] m_axis_data_tdata;
    logic        m_axis_data_tvalid;
    logic        m_axis_data_tready = 1'b0;

    int tests = 0;
    int fails = 0;
    int acc   = 0;
    int cyc   = 0;
    int pat   = 0;
    int hold_err = 0;
    logic        have_held = 1'b0;
    logic [15:0] held_val  = 16'h0;
    logic [15:0] capq[$];
    int          capacc[$];
    int          capcyc[$];

    axis_bitstream_decim #(.WIDTH(16), .DECIM_LOG2(4)) dut (
        .aclk               (aclk),
        .arst               (arst),
        .s_axis_data_tdata  (s_axis_data_tdata),
        .s_axis_data_tvalid (s_axis_data_tvalid),
        .s_axis_data_tready (s_axis_data_tready),
        .m_axis_data_tdata  (m_axis_data_tdata),
        .m_axis_data_tvalid (m_axis_data_tvalid),
        .m_axis_data_tready (m_axis_data_tready)
    );

    always #5 aclk = ~aclk;

    function automatic logic pat_bit(input int p, input int n);
        case (p)
            1:       return 1'b1;
            2:       return (n % 2) == 0;
            3:       return (n % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Observe at the falling edge, then advance one clock and drive the next bit.
    task automatic step();
        logic acc_now;
        @(negedge aclk);
        if (m_axis_data_tvalid && m_axis_data_tready) begin
            capq.push_back(m_axis_data_tdata);
            capacc.push_back(acc);
            capcyc.push_back(cyc);
        end
        if (m_axis_data_tvalid && !m_axis_data_tready) begin
            if (have_held && m_axis_data_tdata !== held_val)
                hold_err++;
            held_val  = m_axis_data_tdata;
            have_held = 1'b1;
        end
        acc_now = s_axis_data_tvalid && s_axis_data_tready;
        @(posedge aclk);
        #1;
        cyc++;
        if (acc_now)
            acc++;
        s_axis_data_tdata = pat_bit(pat, acc);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        s_axis_data_tvalid = 1'b0;
        m_axis_data_tready = 1'b0;
        step();
        step();
        arst = 1'b0;
        acc = 0;
        hold_err = 0;
        have_held = 1'b0;
        capq.delete();
        capacc.delete();
        capcyc.delete();
    endtask

    task automatic run_stream(input string name, input int p, input logic [15:0] e0,
                              input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_q[4];
        logic [31:0] obs;
        exp_q = '{e0, e1, e2, e3};
        do_reset();
        pat = p;
        s_axis_data_tdata  = pat_bit(pat, 0);
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b1;
        repeat (64) step();
        s_axis_data_tvalid = 1'b0;
        repeat (3) step();
        check($sformatf("%s_count", name), 32'(capq.size()), 32'(4 - SKIP));
        for (int k = 0; k < 4 - SKIP; k++) begin
            obs = (k < capq.size()) ? 32'(capq[k]) : 32'hDEAD;
            check($sformatf("%s_sample%0d", name, k), obs, 32'(exp_q[k + SKIP]));
        end
        obs = (capcyc.size() >= 2) ? 32'(capcyc[1] - capcyc[0]) : 32'hDEAD;
        check($sformatf("%s_cadence", name), obs, 32'd16);
    endtask

    initial begin
        logic [31:0] obs;

        // Reset state
        do_reset();
        check("rst_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        check("rst_tdata",  32'(m_axis_data_tdata),  32'd0);
        check("rst_tready", 32'(s_axis_data_tready), 32'd1);

        // Streaming patterns: ones, zeros, 1/2 density, 1/4 density
        run_stream("ones",    1, 16'h7800, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_stream("zeros",   0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_stream("alt",     2, 16'h4000, 16'h8000, 16'h8000, 16'h8000);
        run_stream("quarter", 3, 16'h2400, 16'h4000, 16'h4000, 16'h4000);

        // Downstream backpressure with continuous input
        do_reset();
        pat = 1;
        s_axis_data_tdata  = 1'b1;
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b0;
        repeat (HOLD_CYC) step();
        check("bp_acc_stalled", 32'(acc), 32'(HOLD_ACC));
        check("bp_s_tready_low", 32'(s_axis_data_tready), 32'd0);
        check("bp_tvalid_held", 32'(m_axis_data_tvalid), 32'd1);
        check("bp_tdata_held", 32'(m_axis_data_tdata), 32'(FIRST_ONES));
        check("bp_hold_stable", 32'(hold_err), 32'd0);
        m_axis_data_tready = 1'b1;
        #1;
        check("bp_release_tready", 32'(s_axis_data_tready), 32'd1);
        step();
        check("bp_drain_accept", 32'(acc), 32'(HOLD_ACC + 1));
        check("bp_new_tvalid", 32'(m_axis_data_tvalid), 32'd1);
        check("bp_new_tdata", 32'(m_axis_data_tdata), 32'hFFFF);
        repeat (18) step();
        check("bp_count", 32'(capq.size()), 32'd3);
        obs = (capq.size() >= 1) ? 32'(capq[0]) : 32'hDEAD;
        check("bp_order0", obs, 32'(FIRST_ONES));
        obs = (capq.size() >= 3) ? 32'(capq[2]) : 32'hDEAD;
        check("bp_order2", obs, 32'hFFFF);

        // Reset mid-frame while an output is pending
        do_reset();
        pat = 1;
        s_axis_data_tdata  = 1'b1;
        s_axis_data_tvalid = 1'b1;
        m_axis_data_tready = 1'b0;
        for (int n = 0; n < 100 && acc < PEND_ACC; n++) step();
        check("mid_reach_phase7", 32'(acc), 32'(PEND_ACC));
        check("mid_pending", 32'(m_axis_data_tvalid), 32'd1);
        arst = 1'b1;
        step();
        arst = 1'b0;
        check("mid_rst_tvalid", 32'(m_axis_data_tvalid), 32'd0);
        check("mid_rst_tdata",  32'(m_axis_data_tdata),  32'd0);
        check("mid_rst_tready", 32'(s_axis_data_tready), 32'd1);
        acc = 0;
        capq.delete();
        capacc.delete();
        capcyc.delete();
        m_axis_data_tready = 1'b1;
        repeat (60) step();
        obs = (capacc.size() >= 1) ? 32'(capacc[0]) : 32'hDEAD;
        check("mid_first_out_acc", obs, 32'(FIRST_ACC));
        obs = (capq.size() >= 1) ? 32'(capq[0]) : 32'hDEAD;
        check("mid_first_out_data", obs, 32'(FIRST_ONES));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axis_bitstream_decim.md
# axis_bitstream_decim

Second-order CIC (sinc²) decimator that turns the 1-bit density stream produced by the error-feedback modulator back into WIDTH-bit unsigned PCM samples. It is used as the loopback/monitor path for the DAC modulators, and as the reference receiver in modulator testbenches. It accepts one bit per AXI-Stream beat and emits one sample per 2^DECIM_LOG2 accepted bits, with full tready/tvalid backpressure on both sides.

## Interface
- WIDTH, 16: output sample width. Must satisfy WIDTH > 2*DECIM_LOG2.
- DECIM_LOG2, 4: log2 of the decimation ratio R (R = 2^DECIM_LOG2).
- aclk  in  1  clock; all logic is rising-edge.
- arst  in  1  reset, synchronous, active-high.
- s_axis_data_tdata  in  1  modulator bit; 1 = +full-scale, 0 = zero.
- s_axis_data_tvalid  in  1  input beat valid.
- s_axis_data_tready  out  1  input beat accepted when tvalid & tready.
- m_axis_data_tdata  out  WIDTH  decimated unsigned sample.
- m_axis_data_tvalid  out  1  output sample valid.
- m_axis_data_tready  in  1  downstream accept.

## Operation
- Internal width N = 2*DECIM_LOG2+1. All integrator and comb registers are N-bit unsigned with modular wrap. Wrap is intentional: the true comb output always lies in 0..R², and modular arithmetic recovers it exactly.
- Per accepted input bit b:
  - i1 <= i1 + b
  - i2 <= i2 + i1 (uses the old i1)
  - phase <= phase + 1 (DECIM_LOG2-bit, wraps)
- Frame end is the accepted beat with phase == R-1. On that beat:
  - s = i2 + i1, the value being written to i2.
  - c1 = s - s_d; s_d <= s.
  - c2 = c1 - c1_d; c1_d <= c1.
  - Output register loads sat(c2 << (WIDTH - 2*DECIM_LOG2)). Saturation: c2 == R² maps to 2^WIDTH-1. All other values are exact.
  - m_axis_data_tvalid <= 1.
- m_axis_data_tvalid clears on any cycle with m_tvalid & m_tready that does not also load a new sample. Loading and draining in the same cycle keeps tvalid = 1 with the new data.
- s_axis_data_tready = ~(phase == R-1 & m_axis_data_tvalid & ~m_axis_data_tready). Input stalls only when the next accepted beat would complete a frame while the output register is still occupied. No sample is ever dropped or overwritten.
- m_axis_data_tdata is held stable while tvalid & ~tready.
- Reset clears i1, i2, s_d, c1_d, phase, the output register, m_axis_data_tvalid, and the warm-up counter.
  - After reset: m_axis_data_tvalid = 0, m_axis_data_tdata = 0, s_axis_data_tready = 1.
  - Reset mid-frame discards the partial frame and any unaccepted output sample.
- The first two frames after reset are comb warm-up and carry transient values. Steady-state output is exact from the third frame onward.

## Timing
- Latency: m_axis_data_tvalid rises on the cycle after the clock edge that accepts the frame-end bit.
- Throughput: one input bit per cycle, with no bubbles while downstream keeps up. One output per R accepted bits.
- tready is combinational from m_axis_data_tready and registered state. There is no combinational path from s_axis_data_tvalid to any output.
- A stalled frame-end beat is accepted in the same cycle that m_axis_data_tready drains the old sample. The new sample is valid on the next cycle.

## Configuration
- DECIM_WARMUP_MASK_EN:
  - Defined: a 2-bit warm-up counter suppresses m_axis_data_tvalid for the first two frames after reset. Integrators and combs still update during these frames, and input is never stalled by masked frames. The first visible sample is steady-state.
  - Undefined: every frame, including warm-up frames, is presented on the output.

## Test plan
All cases use WIDTH=16, DECIM_LOG2=4 (R=16).
- Constant all-ones input, m_tready=1: from frame 3 onward, every output is 0xFFFF (saturated 256<<8). Outputs arrive every 16 cycles.
- Constant all-zeros input: every output is 0x0000, including warm-up frames.
- Alternating 1,0 input: steady-state output is 0x8000 (128<<8).
- Driving the error-feedback modulator with constant 0x4000 into this block: steady-state output is exactly 0x4000.
- Hold m_tready=0 for 40 cycles with continuous valid input:
  - tready drops when phase=15 while the first sample is pending.
  - The held m_tdata stays constant throughout.
  - After m_tready returns, the stalled bit is accepted in the drain cycle, and output samples stay in order with none lost.
- Assert arst at phase=7 while an output is pending: the next cycle shows tvalid=0, tdata=0, tready=1. With DECIM_WARMUP_MASK_EN defined, the first output appears only after 48 accepted bits.
